// File: rtl/jpeg_raster_reorder.sv
// jpeg_raster_reorder
//   Block-to-raster reorder buffer. Pixels arrive in MCU order (block after
//   block, row-major inside each BLK x BLK block) and leave in raster order
//   across the full image width. Two MCU-row banks ping-pong, so one bank
//   fills while the other drains, at up to one pixel per clock each way.
//
// Parameters
//   BLK     block side in pixels (8 or 16)
//   IMG_BW  image width in blocks
//   DW      pixel word width
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   ai_we     input pixel valid
//   ao_next   input ready (transfer on ai_we & ao_next)
//   ai_data   input pixel
//   ai_begin  first pixel of frame (restarts the current bank at address 0)
//   ai_end    last pixel of frame (closes the current bank)
//   bo_we     output pixel valid
//   bi_next   output ready (transfer on bo_we & bi_next)
//   bo_data   output pixel
//   bo_sol    output pixel is at raster column 0
//   bo_end    output pixel is the last pixel of the frame
//   bo_err    sticky framing error (only when JPEG_REORDER_ERR_EN is defined)
//
// Build option
//   JPEG_REORDER_ERR_EN  adds the bo_err port and its framing checker.

module jpeg_raster_reorder #(
  parameter int BLK    = 16,
  parameter int IMG_BW = 61,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ai_we,
  output logic          ao_next,
  input  logic [DW-1:0] ai_data,
  input  logic          ai_begin,
  input  logic          ai_end,
  output logic          bo_we,
  input  logic          bi_next,
  output logic [DW-1:0] bo_data,
  output logic          bo_sol,
  output logic          bo_end
`ifdef JPEG_REORDER_ERR_EN
  ,
  output logic          bo_err
`endif
);

  localparam int IMG_W = BLK * IMG_BW;
  localparam int BANK  = BLK * IMG_W;
  localparam int PIX   = BLK * BLK;
  localparam int LB    = $clog2(BLK);
  localparam int WPW   = $clog2(PIX);
  localparam int WBW   = (IMG_BW > 1) ? $clog2(IMG_BW) : 1;
  localparam int RCW   = $clog2(BANK);
  localparam int CW    = $clog2(IMG_W);

  localparam logic [WPW-1:0] WP_LAST  = WPW'(PIX - 1);
  localparam logic [WBW-1:0] WBX_LAST = WBW'(IMG_BW - 1);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(BANK - 1);
  localparam logic [RCW-1:0] IMG_W_A  = RCW'(IMG_W);
  localparam logic [RCW-1:0] BLK_A    = RCW'(BLK);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);

  // bank bookkeeping
  logic       wsel, rsel;
  logic [1:0] full, full_d, last;

  // write side
  logic [WPW-1:0] wp, wp_eff;
  logic [WBW-1:0] wbx, wbx_eff;
  logic [RCW-1:0] waddr;
  logic           wr_go, wr_final, wr_close;

  // read side
  logic [RCW-1:0] rc;
  logic [CW-1:0]  rcol;
  logic           rd_issue, rd_v, rd_sol, rd_end;
  logic [DW-1:0]  ram_q;

  // output skid buffer
  logic [1:0]    cnt, occ;
  logic          pop;
  logic [DW+1:0] q0, q1, push_w;

  logic [DW-1:0] mem [0:2*BANK-1];

  //--------------------------------------------------------------------------
  // Write side
  //--------------------------------------------------------------------------
  assign ao_next = ~full[wsel];
  assign wr_go   = ai_we & ao_next;

  // ai_begin forces this pixel to position 0 and drops any partial content.
  assign wp_eff   = ai_begin ? '0 : wp;
  assign wbx_eff  = ai_begin ? '0 : wbx;
  assign wr_final = (wp_eff == WP_LAST) && (wbx_eff == WBX_LAST);
  assign wr_close = wr_final | ai_end;

  // (wp/BLK)*IMG_W + wbx*BLK + wp%BLK ; BLK is a power of two
  assign waddr = RCW'(wp_eff[WPW-1:LB]) * IMG_W_A
               + RCW'(wbx_eff) * BLK_A
               + RCW'(wp_eff[LB-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      wbx <= '0;
    end else if (wr_go) begin
      if (wr_close) begin
        wp  <= '0;
        wbx <= '0;
      end else if (wp_eff == WP_LAST) begin
        wp  <= '0;
        wbx <= wbx_eff + WBW'(1);
      end else begin
        wp  <= wp_eff + WPW'(1);
        wbx <= wbx_eff;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Bank flags. A set (write close) and a clear (read done) can only ever
  // target different banks, so both are applied in the same cycle.
  //--------------------------------------------------------------------------
  always_comb begin
    full_d = full;
    if (wr_go && wr_close)
      full_d[wsel] = 1'b1;
    if (rd_issue && (rc == RC_LAST))
      full_d[rsel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
      last <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
    end else begin
      full <= full_d;
      if (wr_go && wr_close) begin
        last[wsel] <= ai_end;
        wsel       <= ~wsel;
      end
      if (rd_issue && (rc == RC_LAST))
        rsel <= ~rsel;
    end
  end

  //--------------------------------------------------------------------------
  // Read side. A read is issued only if the pixel it returns is guaranteed a
  // slot in the skid buffer next cycle (buffered + in flight - leaving <= 1).
  //--------------------------------------------------------------------------
  assign bo_we = (cnt != 2'd0);
  assign pop   = bo_we & bi_next;
  assign occ   = cnt + {1'b0, rd_v};

  always_comb begin
    rd_issue = 1'b0;
    if (full[rsel] && ((occ < 2'd2) || pop))
      rd_issue = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc     <= '0;
      rcol   <= '0;
      rd_v   <= 1'b0;
      rd_sol <= 1'b0;
      rd_end <= 1'b0;
    end else begin
      rd_v <= rd_issue;
      if (rd_issue) begin
        rd_sol <= (rcol == '0);
        rd_end <= (rc == RC_LAST) && last[rsel];
        // BANK is a multiple of IMG_W, so rcol wraps together with rc
        if (rc == RC_LAST) begin
          rc   <= '0;
          rcol <= '0;
        end else begin
          rc   <= rc + RCW'(1);
          rcol <= (rcol == COL_LAST) ? '0 : rcol + CW'(1);
        end
      end
    end
  end

  // Pixel RAM: never reset, so unwritten positions keep stale content.
  always_ff @(posedge clk) begin
    if (wr_go)
      mem[{wsel, waddr}] <= ai_data;
    if (rd_issue)
      ram_q <= mem[{rsel, rc}];
  end

  //--------------------------------------------------------------------------
  // 2-entry output buffer; q0 is the presented pixel and only moves on pop.
  //--------------------------------------------------------------------------
  assign push_w = {ram_q, rd_sol, rd_end};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 2'd0;
      q0  <= '0;
      q1  <= '0;
    end else begin
      case ({rd_v, pop})
        2'b10: begin
          if (cnt == 2'd0) q0 <= push_w;
          else             q1 <= push_w;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          q0  <= q1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q0 <= push_w;
          end else begin
            q0 <= q1;
            q1 <= push_w;
          end
        end
        default: ;
      endcase
    end
  end

  assign bo_data = q0[DW+1:2];
  assign bo_sol  = q0[1];
  assign bo_end  = q0[0];

`ifdef JPEG_REORDER_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bo_err <= 1'b0;
    else if (wr_go && ((ai_end && !wr_final) ||
                       (ai_begin && ((wp != '0) || (wbx != '0)))))
      bo_err <= 1'b1;
  end
`endif

endmodule
